regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data width in bits.
REQ-002 SHALL provide parameter NREG, default 32, register count (power of 2, >=2); AW = clog2(NREG).
REQ-003 SHALL provide parameter BYPASS, default 1; 1 = write-to-read forwarding enabled, 0 = disabled.
REQ-004 i_clk  in  1  clock; all state updates on rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-low.
REQ-006 i_rs1_addr, i_rs2_addr  in  AW  read-port addresses.
REQ-007 o_rs1_data, o_rs2_data  out  XLEN  read data (combinational).
REQ-008 o_rs1_busy, o_rs2_busy  out  1  source register has a pending write.
REQ-009 i_wa_en, i_wa_addr, i_wa_data  in  1/AW/XLEN  write port A (ALU writeback).
REQ-010 i_wb_en, i_wb_addr, i_wb_data  in  1/AW/XLEN  write port B (load writeback).
REQ-011 i_iss_en, i_iss_rd  in  1/AW  issue: mark destination pending.
REQ-012 o_iss_stall  out  1  issue blocked by hazard.
REQ-013 o_busy_vec  out  NREG  scoreboard pending bits, bit n = register n.

Function
REQ-014 Register 0 SHALL read as zero, never be written, never be marked busy.
REQ-015 Read data SHALL equal stored value of the addressed register, combinational, zero cycles latency.
REQ-016 With BYPASS=1, a read whose address equals an enabled, non-zero write address in the same cycle SHALL return that write data; port B SHALL take priority over port A.
REQ-017 With BYPASS=0, reads SHALL return the pre-edge stored value.
REQ-018 Write ports A and B SHALL update storage on the clock edge when enabled and address != 0.
REQ-019 Simultaneous A/B writes to the same address SHALL store port B data.
REQ-020 Issue (i_iss_en=1, o_iss_stall=0, i_iss_rd != 0) SHALL set busy bit i_iss_rd on the next edge.
REQ-021 Enabled write to register n SHALL clear busy bit n on the next edge.
REQ-022 Same-cycle accepted issue and writeback to the same register: set SHALL win (bit stays 1).
REQ-023 o_rsX_busy SHALL be 1 when busy bit of i_rsX_addr is 1 and not cleared by a same-cycle write (with BYPASS=1); with BYPASS=0, the same-cycle write does not mask busy.
REQ-024 o_iss_stall SHALL be 1 when i_iss_en=1 and (o_rs1_busy or o_rs2_busy or busy bit of i_iss_rd is set and not cleared this cycle) (WAW guard); 0 when i_iss_en=0.
REQ-025 Stalled issue SHALL NOT modify the scoreboard.
REQ-026 Writes to registers not busy SHALL still update storage (no scoreboard check on writeback).
REQ-027 Out-of-range addresses cannot occur (NREG power of 2); no error flag.

Reset
REQ-028 When i_rst=0 at an edge, all registers and all busy bits SHALL become 0, overriding writes and issue in that cycle.
REQ-029 During reset cycle, outputs SHALL still be combinational from pre-edge state; after the edge all read data = 0, o_busy_vec = 0, o_iss_stall = 0 unless inputs select a busy register.
REQ-030 Reset mid-operation SHALL discard all pending writes (busy bits) without completion.

Verification
REQ-031 Reset, then read x0..x31 -> all 0, o_busy_vec=0.
REQ-032 Write A x5=0x1234_5678, B x5=0xDEAD_BEEF same cycle, read rs1=x5 same cycle (BYPASS=1) -> 0xDEAD_BEEF; next cycle stored 0xDEAD_BEEF.
REQ-033 Write x0=0xFFFF_FFFF, issue rd=x0 -> rs1=x0 reads 0, busy bit 0 stays 0, no stall.
REQ-034 Issue rd=x7; next cycle read rs1=x7 -> o_rs1_busy=1, issue with rs2=x7 stalls; write A x7=0x55 -> busy clears same cycle (BYPASS=1), o_rs1_data=0x55, stall deasserts.
REQ-035 Busy x9, same cycle write B x9 and issue rd=x9 -> o_busy_vec[9]=1 after edge, x9 stored value = write data.
REQ-036 Issue rd=x3, assert i_rst=0 with write A x4=0x99 same cycle -> after edge x4=0, o_busy_vec=0.

Source files
------------

// File: rtl/regfile_sb.sv
// Multi-ported integer register file with a pending-write scoreboard.
// Two writeback ports, two combinational read ports, and an issue port that marks destinations busy.
module regfile_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned BYPASS = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [$clog2(NREG)-1:0]  i_rs1_addr,
    input  logic [$clog2(NREG)-1:0]  i_rs2_addr,
    output logic [XLEN-1:0]          o_rs1_data,
    output logic [XLEN-1:0]          o_rs2_data,
    output logic                     o_rs1_busy,
    output logic                     o_rs2_busy,
    input  logic                     i_wa_en,
    input  logic [$clog2(NREG)-1:0]  i_wa_addr,
    input  logic [XLEN-1:0]          i_wa_data,
    input  logic                     i_wb_en,
    input  logic [$clog2(NREG)-1:0]  i_wb_addr,
    input  logic [XLEN-1:0]          i_wb_data,
    input  logic                     i_iss_en,
    input  logic [$clog2(NREG)-1:0]  i_iss_rd,
    output logic                     o_iss_stall,
    output logic [NREG-1:0]          o_busy_vec
);

    localparam int unsigned AW = $clog2(NREG);
    localparam bit FWD = (BYPASS != 0);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] busy_live;
    logic [NREG-1:0] busy_rd;
    logic            wa_hit;
    logic            wb_hit;
    logic            iss_accept;

    // Writes to x0 are dropped everywhere, so they neither store, forward nor clear.
    assign wa_hit = i_wa_en && (i_wa_addr != AW'(0));
    assign wb_hit = i_wb_en && (i_wb_addr != AW'(0));

    // Pending bits retired by this cycle's writebacks
    always_comb begin
        clr_vec = '0;
        if (wa_hit) clr_vec[i_wa_addr] = 1'b1;
        if (wb_hit) clr_vec[i_wb_addr] = 1'b1;
    end

    assign busy_live = busy & ~clr_vec;
    assign busy_rd   = FWD ? busy_live : busy;

    // Read mux: port B forward beats port A forward beats storage.
    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        logic [XLEN-1:0] val;
        val = '0;
        if (addr != AW'(0)) begin
            if (FWD && wb_hit && (i_wb_addr == addr))
                val = i_wb_data;
            else if (FWD && wa_hit && (i_wa_addr == addr))
                val = i_wa_data;
            else
                val = regs[addr];
        end
        return val;
    endfunction

    always_comb begin
        o_rs1_data = read_port(i_rs1_addr);
        o_rs2_data = read_port(i_rs2_addr);
        o_rs1_busy = busy_rd[i_rs1_addr];
        o_rs2_busy = busy_rd[i_rs2_addr];
    end

    // RAW on either source or WAW on the destination holds the issue.
    always_comb begin
        o_iss_stall = 1'b0;
        if (i_iss_en)
            o_iss_stall = o_rs1_busy || o_rs2_busy || busy_live[i_iss_rd];
    end

    assign iss_accept = i_iss_en && !o_iss_stall && (i_iss_rd != AW'(0));
    assign set_vec    = iss_accept ? (NREG'(1) << i_iss_rd) : '0;
    assign o_busy_vec = busy;

    // Scoreboard: an accepted issue overrides a same-cycle retire of the same register.
    always_ff @(posedge i_clk) begin
        if (!i_rst)
            busy <= '0;
        else
            busy <= busy_live | set_vec;
    end

    // Storage: the later port B assignment gives it priority on an address collision.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int unsigned i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else begin
            if (wa_hit) regs[i_wa_addr] <= i_wa_data;
            if (wb_hit) regs[i_wb_addr] <= i_wb_data;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector bench for regfile_sb: reset sweep, then a stateful vector table.
// A second instance with forwarding disabled shares the inputs and is spot-checked.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, wa_addr, wb_addr, iss_rd;
    logic        wa_en, wb_en, iss_en;
    logic [31:0] wa_data, wb_data;
    logic [31:0] rs1_data, rs2_data, z_rs1_data, z_rs2_data;
    logic        rs1_busy, rs2_busy, iss_stall;
    logic        z_rs1_busy, z_rs2_busy, z_iss_stall;
    logic [31:0] busy_vec, z_busy_vec;

    int n_vec  = 0;
    int n_miss = 0;

    regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
        .o_rs1_data(rs1_data), .o_rs2_data(rs2_data),
        .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy),
        .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data),
        .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .i_iss_en(iss_en), .i_iss_rd(iss_rd),
        .o_iss_stall(iss_stall), .o_busy_vec(busy_vec)
    );

    regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(0)) dut_nofwd (
        .i_clk(clk), .i_rst(rst),
        .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
        .o_rs1_data(z_rs1_data), .o_rs2_data(z_rs2_data),
        .o_rs1_busy(z_rs1_busy), .o_rs2_busy(z_rs2_busy),
        .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data),
        .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .i_iss_en(iss_en), .i_iss_rd(iss_rd),
        .o_iss_stall(z_iss_stall), .o_busy_vec(z_busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rst, rs1, rs2;
        logic [31:0] wa_en, wa_addr, wa_data;
        logic [31:0] wb_en, wb_addr, wb_data;
        logic [31:0] iss_en, iss_rd;
        logic [31:0] e_rs1, e_rs2, e_b1, e_b2, e_stall, e_vec;
        logic [31:0] chk0, e0_rs1, e0_b1, e0_stall;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s (vec %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        iss_en = 1'b0; iss_rd = '0;
    endtask

    initial begin
        //          rst rs1 rs2  waE waA waD           wbE wbA wbD           iE iRd  eRs1          eRs2          b1 b2 st eVec    chk0 e0r e0b e0s
        vecs[0]  = '{1, 5,  0,   1,  5,  32'h12345678, 1,  5,  32'hDEADBEEF, 0, 0,   32'hDEADBEEF, 0,            0, 0, 0, 32'h0,   1,   0,  0,  0};
        vecs[1]  = '{1, 5,  6,   0,  0,  0,            0,  0,  0,            0, 0,   32'hDEADBEEF, 0,            0, 0, 0, 32'h0,   0,   0,  0,  0};
        vecs[2]  = '{1, 0,  5,   1,  0,  32'hFFFFFFFF, 0,  0,  0,            1, 0,   0,            32'hDEADBEEF, 0, 0, 0, 32'h0,   0,   0,  0,  0};
        vecs[3]  = '{1, 0,  0,   0,  0,  0,            0,  0,  0,            0, 0,   0,            0,            0, 0, 0, 32'h0,   0,   0,  0,  0};
        vecs[4]  = '{1, 1,  2,   0,  0,  0,            0,  0,  0,            1, 7,   0,            0,            0, 0, 0, 32'h0,   0,   0,  0,  0};
        vecs[5]  = '{1, 7,  1,   0,  0,  0,            0,  0,  0,            0, 0,   0,            0,            1, 0, 0, 32'h80,  0,   0,  0,  0};
        vecs[6]  = '{1, 7,  7,   0,  0,  0,            0,  0,  0,            1, 8,   0,            0,            1, 1, 1, 32'h80,  0,   0,  0,  0};
        vecs[7]  = '{1, 1,  2,   0,  0,  0,            0,  0,  0,            1, 7,   0,            0,            0, 0, 1, 32'h80,  0,   0,  0,  0};
        vecs[8]  = '{1, 7,  7,   1,  7,  32'h55,       0,  0,  0,            1, 8,   32'h55,       32'h55,       0, 0, 0, 32'h80,  1,   0,  1,  1};
        vecs[9]  = '{1, 7,  8,   0,  0,  0,            0,  0,  0,            0, 0,   32'h55,       0,            0, 1, 0, 32'h100, 0,   0,  0,  0};
        vecs[10] = '{1, 0,  0,   0,  0,  0,            0,  0,  0,            1, 9,   0,            0,            0, 0, 0, 32'h100, 0,   0,  0,  0};
        vecs[11] = '{1, 9,  0,   0,  0,  0,            1,  9,  32'hCAFEF00D, 1, 9,   32'hCAFEF00D, 0,            0, 0, 0, 32'h300, 0,   0,  0,  0};
        vecs[12] = '{1, 9,  8,   0,  0,  0,            0,  0,  0,            0, 0,   32'hCAFEF00D, 0,            1, 1, 0, 32'h300, 0,   0,  0,  0};
        vecs[13] = '{1, 10, 8,   1,  10, 32'hA5A5A5A5, 1,  8,  32'h11112222, 0, 0,   32'hA5A5A5A5, 32'h11112222, 0, 0, 0, 32'h300, 0,   0,  0,  0};
        vecs[14] = '{1, 10, 8,   0,  0,  0,            0,  0,  0,            0, 0,   32'hA5A5A5A5, 32'h11112222, 0, 0, 0, 32'h200, 0,   0,  0,  0};
        vecs[15] = '{1, 12, 13,  1,  12, 32'hFF,       1,  13, 32'hABC,      0, 0,   32'hFF,       32'hABC,      0, 0, 0, 32'h200, 0,   0,  0,  0};
        vecs[16] = '{1, 12, 13,  0,  0,  0,            0,  0,  0,            0, 0,   32'hFF,       32'hABC,      0, 0, 0, 32'h200, 0,   0,  0,  0};
        vecs[17] = '{0, 4,  3,   1,  4,  32'h99,       0,  0,  0,            1, 3,   32'h99,       0,            0, 0, 0, 32'h200, 0,   0,  0,  0};
        vecs[18] = '{1, 4,  9,   0,  0,  0,            0,  0,  0,            0, 0,   0,            0,            0, 0, 0, 32'h0,   0,   0,  0,  0};
        vecs[19] = '{1, 5,  12,  0,  0,  0,            0,  0,  0,            0, 0,   0,            0,            0, 0, 0, 32'h0,   0,   0,  0,  0};

        // Reset, then sweep every register on both read ports.
        rst = 1'b0; rs1_addr = '0; rs2_addr = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            @(negedge clk);
            check("reset_rs1", i, rs1_data, 32'h0);
            check("reset_rs2", i, rs2_data, 32'h0);
            check("reset_busy1", i, {31'b0, rs1_busy}, 32'h0);
        end
        check("reset_busy_vec", 0, busy_vec, 32'h0);
        check("reset_stall", 0, {31'b0, iss_stall}, 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            rst      = vecs[i].rst[0];
            rs1_addr = 5'(vecs[i].rs1);
            rs2_addr = 5'(vecs[i].rs2);
            wa_en    = vecs[i].wa_en[0];
            wa_addr  = 5'(vecs[i].wa_addr);
            wa_data  = vecs[i].wa_data;
            wb_en    = vecs[i].wb_en[0];
            wb_addr  = 5'(vecs[i].wb_addr);
            wb_data  = vecs[i].wb_data;
            iss_en   = vecs[i].iss_en[0];
            iss_rd   = 5'(vecs[i].iss_rd);
            @(negedge clk);
            check("rs1_data", i, rs1_data, vecs[i].e_rs1);
            check("rs2_data", i, rs2_data, vecs[i].e_rs2);
            check("rs1_busy", i, {31'b0, rs1_busy}, vecs[i].e_b1);
            check("rs2_busy", i, {31'b0, rs2_busy}, vecs[i].e_b2);
            check("iss_stall", i, {31'b0, iss_stall}, vecs[i].e_stall);
            check("busy_vec", i, busy_vec, vecs[i].e_vec);
            if (vecs[i].chk0[0]) begin
                check("nofwd_rs1_data", i, z_rs1_data, vecs[i].e0_rs1);
                check("nofwd_rs1_busy", i, {31'b0, z_rs1_busy}, vecs[i].e0_b1);
                check("nofwd_iss_stall", i, {31'b0, z_iss_stall}, vecs[i].e0_stall);
            end
            @(posedge clk);
            #1;
        end

        // Without forwarding, the committed value is visible only after the edge.
        rst = 1'b1; idle_inputs();
        rs1_addr = 5'd20; rs2_addr = 5'd20;
        wa_en = 1'b1; wa_addr = 5'd20; wa_data = 32'h0BAD_F00D;
        @(negedge clk);
        check("nofwd_pre_edge", 0, z_rs1_data, 32'h0);
        check("fwd_pre_edge", 0, rs1_data, 32'h0BAD_F00D);
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        check("nofwd_post_edge", 1, z_rs2_data, 32'h0BAD_F00D);
        check("fwd_post_edge", 1, rs2_data, 32'h0BAD_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
